// File: rtl/imem_line_responder.sv
// Fetch-side instruction responder: serves hits from a single line buffer and
// refills it word by word over a req/ack memory bus on a miss.
module imem_line_responder #(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_kill,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        stall,
    output logic        fetch_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned BEAT_BITS = $clog2(LINE_WORDS);
    localparam int unsigned OFF_BITS  = BEAT_BITS + 2;
    localparam int unsigned TAG_BITS  = 32 - OFF_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t               state_reg, state_next;
    logic                 line_valid_reg, line_valid_next;
    logic [TAG_BITS-1:0]  tag_reg, tag_next;
    logic [TAG_BITS-1:0]  fill_tag_reg, fill_tag_next;
    logic [BEAT_BITS-1:0] beat_cnt_reg, beat_cnt_next;
    logic                 mem_req_reg, mem_req_next;
    logic [31:0]          mem_addr_reg, mem_addr_next;
    logic                 word_we;
    logic [31:0]          line_data [LINE_WORDS];

    logic                 misaligned;
    logic                 tag_hit;
    logic                 miss;
    logic [TAG_BITS-1:0]  fetch_tag;
    logic [BEAT_BITS-1:0] word_sel;

    assign misaligned = |fetch_addr[1:0];
    assign fetch_tag  = fetch_addr[31:OFF_BITS];
    assign word_sel   = fetch_addr[OFF_BITS-1:2];
    assign tag_hit    = line_valid_reg && (tag_reg == fetch_tag);
    assign miss       = !misaligned && !tag_hit;

    // Outside IDLE the line is being rewritten, so nothing may be served from it.
    assign stall     = (state_reg != IDLE) || miss;
    assign fetch_err = misaligned;
    assign inst      = misaligned ? NOP_INST : line_data[word_sel];
    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            line_valid_reg <= 1'b0;
            tag_reg        <= '0;
            fill_tag_reg   <= '0;
            beat_cnt_reg   <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            line_valid_reg <= line_valid_next;
            tag_reg        <= tag_next;
            fill_tag_reg   <= fill_tag_next;
            beat_cnt_reg   <= beat_cnt_next;
            mem_req_reg    <= mem_req_next;
            mem_addr_reg   <= mem_addr_next;
        end
    end

    // Data words carry no reset; line_valid guards their use.
    always_ff @(posedge clk) begin
        if (word_we) begin
            line_data[beat_cnt_reg] <= mem_rdata;
        end
    end

    always_comb begin
        state_next      = state_reg;
        line_valid_next = line_valid_reg;
        tag_next        = tag_reg;
        fill_tag_next   = fill_tag_reg;
        beat_cnt_next   = beat_cnt_reg;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        word_we         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (flush) begin
                    line_valid_next = 1'b0;
                end
                if (miss) begin
                    fill_tag_next   = fetch_tag;
                    line_valid_next = 1'b0;
                    beat_cnt_next   = '0;
                    mem_req_next    = 1'b1;
                    mem_addr_next   = {fetch_tag, {BEAT_BITS{1'b0}}, 2'b00};
                    state_next      = FILL;
                end
            end

            FILL: begin
                if (fetch_kill || flush) begin
                    // An ack in the kill cycle retires the request; otherwise wait it out.
                    if (mem_ack) begin
                        mem_req_next = 1'b0;
                        state_next   = IDLE;
                    end else begin
                        state_next   = DRAIN;
                    end
                end else if (mem_ack) begin
                    word_we       = 1'b1;
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (beat_cnt_reg == LAST_BEAT) begin
                        line_valid_next = 1'b1;
                        tag_next        = fill_tag_reg;
                        mem_req_next    = 1'b0;
                        state_next      = IDLE;
                    end else begin
                        mem_addr_next = {fill_tag_reg, beat_cnt_next, 2'b00};
                    end
                end
            end

            DRAIN: begin
                if (mem_ack) begin
                    mem_req_next = 1'b0;
                    state_next   = IDLE;
                end
            end

            default: begin
                mem_req_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: cold fill, hits, wait states, kill,
// misaligned fetches, flush and asynchronous reset during a refill.
module tb_imem_line_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_kill;
    logic        flush;
    logic [31:0] inst;
    logic        stall;
    logic        fetch_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;

    imem_line_responder #(
        .LINE_WORDS(4),
        .NOP_INST  (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_addr(fetch_addr),
        .fetch_kill(fetch_kill),
        .flush     (flush),
        .inst      (inst),
        .stall     (stall),
        .fetch_err (fetch_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset      = 1'b0;
        fetch_addr = 32'h0;
        fetch_kill = 1'b0;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        vectors++;
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
        vectors++;
        if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", stall); end
        vectors++;
        if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err); end
        $display("reset: mem_req=%b mem_addr=%h stall=%b", mem_req, mem_addr, stall);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_cold_fetch();
        fetch_addr = 32'h0;
        for (int c = 0; c <= 5; c++) begin
            mem_ack   = (c >= 1 && c <= 4);
            mem_rdata = 32'((c - 1) * 4);
            @(negedge clk);
            vectors++;
            if (stall !== (c < 5)) begin errors++; $display("FAIL cold_stall c%0d: got %b expected %b", c, stall, (c < 5)); end
            vectors++;
            if (mem_req !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL cold_mem_req c%0d: got %b expected %b", c, mem_req, (c >= 1 && c <= 4)); end
            if (c >= 1 && c <= 4) begin
                vectors++;
                if (mem_addr !== 32'((c - 1) * 4)) begin errors++; $display("FAIL cold_mem_addr c%0d: got %h expected %h", c, mem_addr, 32'((c - 1) * 4)); end
            end
            if (c == 5) begin
                vectors++;
                if (inst !== 32'h0) begin errors++; $display("FAIL cold_inst: got %h expected 00000000", inst); end
            end
            $display("cold c%0d: stall=%b mem_req=%b mem_addr=%h inst=%h", c, stall, mem_req, mem_addr, inst);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_sequential_hits();
        for (int i = 1; i <= 3; i++) begin
            fetch_addr = 32'(i * 4);
            @(negedge clk);
            vectors++;
            if (stall !== 1'b0) begin errors++; $display("FAIL hit_stall %h: got %b expected 0", fetch_addr, stall); end
            vectors++;
            if (inst !== 32'(i * 4)) begin errors++; $display("FAIL hit_inst %h: got %h expected %h", fetch_addr, inst, 32'(i * 4)); end
            vectors++;
            if (mem_req !== 1'b0) begin errors++; $display("FAIL hit_mem_req %h: got %b expected 0", fetch_addr, mem_req); end
            $display("hit %h: stall=%b inst=%h mem_req=%b", fetch_addr, stall, inst, mem_req);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wait_states();
        fetch_addr = 32'h10;
        for (int c = 0; c <= 14; c++) begin
            int k;
            int beat;
            k    = c - 1;
            beat = (c >= 1) ? k / 3 : 0;
            if (c == 14) fetch_addr = 32'h1C;
            mem_ack   = (c >= 1 && c <= 12) && (k % 3 == 2);
            mem_rdata = 32'(32'h10 + beat * 4);
            @(negedge clk);
            if (c <= 12) begin
                vectors++;
                if (stall !== 1'b1) begin errors++; $display("FAIL wait_stall c%0d: got %b expected 1", c, stall); end
                vectors++;
                if (mem_req !== (c >= 1)) begin errors++; $display("FAIL wait_mem_req c%0d: got %b expected %b", c, mem_req, (c >= 1)); end
                if (c >= 1) begin
                    vectors++;
                    if (mem_addr !== 32'(32'h10 + beat * 4)) begin errors++; $display("FAIL wait_mem_addr c%0d: got %h expected %h", c, mem_addr, 32'(32'h10 + beat * 4)); end
                end
            end else begin
                vectors++;
                if (stall !== 1'b0) begin errors++; $display("FAIL wait_hit_stall c%0d: got %b expected 0", c, stall); end
                vectors++;
                if (inst !== fetch_addr) begin errors++; $display("FAIL wait_hit_inst c%0d: got %h expected %h", c, inst, fetch_addr); end
                vectors++;
                if (mem_req !== 1'b0) begin errors++; $display("FAIL wait_hit_mem_req c%0d: got %b expected 0", c, mem_req); end
            end
            $display("wait c%0d: ack=%b stall=%b mem_req=%b mem_addr=%h inst=%h", c, mem_ack, stall, mem_req, mem_addr, inst);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_kill_mid_fill();
        for (int c = 0; c <= 10; c++) begin
            logic        exp_req;
            logic [31:0] exp_addr;
            fetch_kill = (c == 2);
            fetch_addr = (c >= 2) ? 32'h0 : 32'h20;
            mem_ack    = (c == 1) || (c == 4) || (c >= 6 && c <= 9);
            mem_rdata  = (c == 1) ? 32'h20 : (c == 4) ? 32'hDEAD_0024 : 32'((c - 6) * 4);
            exp_req    = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
            exp_addr   = (c == 1) ? 32'h20 : (c <= 4) ? 32'h24 : 32'((c - 6) * 4);
            @(negedge clk);
            vectors++;
            if (stall !== (c != 10)) begin errors++; $display("FAIL kill_stall c%0d: got %b expected %b", c, stall, (c != 10)); end
            vectors++;
            if (mem_req !== exp_req) begin errors++; $display("FAIL kill_mem_req c%0d: got %b expected %b", c, mem_req, exp_req); end
            if (exp_req) begin
                vectors++;
                if (mem_addr !== exp_addr) begin errors++; $display("FAIL kill_mem_addr c%0d: got %h expected %h", c, mem_addr, exp_addr); end
            end
            if (c == 10) begin
                vectors++;
                if (inst !== 32'h0) begin errors++; $display("FAIL kill_inst: got %h expected 00000000", inst); end
            end
            $display("kill c%0d: kill=%b ack=%b stall=%b mem_req=%b mem_addr=%h inst=%h", c, fetch_kill, mem_ack, stall, mem_req, mem_addr, inst);
            @(posedge clk);
            #1;
        end
        fetch_kill = 1'b0;
        mem_ack    = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3];
        addrs[0] = 32'h6;
        addrs[1] = 32'h41;
        addrs[2] = 32'h43;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = addrs[i];
            @(negedge clk);
            vectors++;
            if (fetch_err !== 1'b1) begin errors++; $display("FAIL mis_fetch_err %h: got %b expected 1", fetch_addr, fetch_err); end
            vectors++;
            if (inst !== 32'h0000_0013) begin errors++; $display("FAIL mis_inst %h: got %h expected 00000013", fetch_addr, inst); end
            vectors++;
            if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall %h: got %b expected 0", fetch_addr, stall); end
            vectors++;
            if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_mem_req %h: got %b expected 0", fetch_addr, mem_req); end
            $display("misaligned %h: fetch_err=%b inst=%h stall=%b mem_req=%b", fetch_addr, fetch_err, inst, stall, mem_req);
            @(posedge clk);
            #1;
        end
        fetch_addr = 32'h8;
        @(negedge clk);
        vectors++;
        if ({fetch_err, stall} !== 2'b00) begin errors++; $display("FAIL aligned_after_mis: got err/stall %b expected 00", {fetch_err, stall}); end
        vectors++;
        if (inst !== 32'h8) begin errors++; $display("FAIL aligned_after_mis_inst: got %h expected 00000008", inst); end
        $display("aligned 00000008: fetch_err=%b stall=%b inst=%h", fetch_err, stall, inst);
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush_reset();
        fetch_addr = 32'h4;
        flush      = 1'b1;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_same_cycle_stall: got %b expected 0", stall); end
        vectors++;
        if (inst !== 32'h4) begin errors++; $display("FAIL flush_same_cycle_inst: got %h expected 00000004", inst); end
        $display("flush pulse: stall=%b inst=%h", stall, inst);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        fetch_addr = 32'h0;
        @(negedge clk);
        vectors++;
        if ({stall, mem_req} !== 2'b10) begin errors++; $display("FAIL flush_miss: got stall/req %b expected 10", {stall, mem_req}); end
        $display("after flush: stall=%b mem_req=%b", stall, mem_req);
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            mem_ack   = (c == 0);
            mem_rdata = 32'(c * 4);
            @(negedge clk);
            vectors++;
            if ({stall, mem_req} !== 2'b11) begin errors++; $display("FAIL refill_req c%0d: got stall/req %b expected 11", c, {stall, mem_req}); end
            vectors++;
            if (mem_addr !== 32'(c * 4)) begin errors++; $display("FAIL refill_addr c%0d: got %h expected %h", c, mem_addr, 32'(c * 4)); end
            $display("refill c%0d: stall=%b mem_req=%b mem_addr=%h", c, stall, mem_req, mem_addr);
            if (c == 0) begin
                @(posedge clk);
                #1;
            end
        end
        mem_ack = 1'b0;
        reset   = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL async_reset_mem_req: got %b expected 0", mem_req); end
        vectors++;
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL async_reset_mem_addr: got %h expected 00000000", mem_addr); end
        $display("async reset: mem_req=%b mem_addr=%h", mem_req, mem_addr);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({stall, mem_req} !== 2'b10) begin errors++; $display("FAIL post_reset_idle: got stall/req %b expected 10", {stall, mem_req}); end
        $display("post reset idle: stall=%b mem_req=%b", stall, mem_req);
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL post_reset_refill: got req=%b addr=%h expected req=1 addr=00000000", mem_req, mem_addr); end
        $display("post reset refill: mem_req=%b mem_addr=%h", mem_req, mem_addr);
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_sequential_hits();
        test_wait_states();
        test_kill_mid_fill();
        test_misaligned();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_line_responder.md
# imem_line_responder

Instruction-side responder for the fetch stage. It takes the fetch address driven by the IF stage and returns the 32-bit instruction word for it. Hits are served combinationally from a single 4-word line buffer. On a miss it holds the IF stage with `stall` and refills the line from external instruction memory over a req/ack word bus. It sits between the IF stage's `address`/`inst`/`stop` signals and the instruction memory port.

## Interface

**Parameters**
- `LINE_WORDS`, default 4: words per line buffer. Must be a power of 2, ≥2.
- `NOP_INST`, default 32'h00000013: word returned on a misaligned fetch.

**Ports**
- `clk`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `fetch_addr`  in  32  — byte address from the IF stage.
- `fetch_kill`  in  1  — IF pipeline kill (redirect); aborts a refill.
- `flush`  in  1  — invalidate the line buffer (fence.i).
- `inst`  out  32  — instruction word for `fetch_addr`; valid when `stall`=0.
- `stall`  out  1  — to IF `stop`; 1 while `inst` is not valid.
- `fetch_err`  out  1  — 1 when `fetch_addr[1:0]`≠0.
- `mem_req`  out  1  — memory read request.
- `mem_addr`  out  32  — word-aligned memory read address.
- `mem_ack`  in  1  — memory beat accepted; `mem_rdata` valid this cycle.
- `mem_rdata`  in  32  — memory read data.

## Operation

**Line buffer**
- Holds `LINE_WORDS` data words, a tag `addr[31:log2(LINE_WORDS)+2]` and one `line_valid` bit.
- Hit: `line_valid`=1, the tag matches, and the FSM is in IDLE. Then `inst` = word[`fetch_addr[log2(LINE_WORDS)+1:2]`] and `stall`=0, combinationally.

**Misaligned fetch**
- `fetch_addr[1:0]`≠0 → `fetch_err`=1, `inst`=`NOP_INST`, `stall`=0.
- No refill is started. Misalignment has priority over hit/miss.

**FSM states**
- IDLE
  - Aligned miss → `stall`=1 combinationally. On the next edge: latch `fill_tag` from `fetch_addr`, clear `line_valid`, clear `beat_cnt` to 0, go to FILL.
- FILL
  - `mem_req`=1 and `mem_addr` = {`fill_tag`, `beat_cnt`, 2'b00}. Both are held stable until `mem_ack`.
  - On an edge with `mem_ack`=1: write `mem_rdata` into word[`beat_cnt`] and increment `beat_cnt`.
  - On the ack of beat `LINE_WORDS`-1: set `line_valid`, set tag = `fill_tag`, go to IDLE.
  - `stall`=1 throughout FILL.
- DRAIN
  - Entered when `fetch_kill` or `flush` is seen in FILL while `mem_req` is outstanding, i.e. `mem_ack`=0 in that cycle.
  - `mem_req` and `mem_addr` are held until `mem_ack`. The data is discarded, `line_valid` stays 0, then go to IDLE.
  - If `mem_ack`=1 in the same cycle as the kill, go directly to IDLE and discard that beat.
  - `stall`=1 in DRAIN.

**Other rules**
- `flush` in IDLE clears `line_valid` on the next edge. A fetch in the same cycle as `flush` is still served as a hit from the pre-flush line.
- `fetch_kill` in IDLE has no effect; the new `fetch_addr` is simply looked up.
- `beat_cnt` is `log2(LINE_WORDS)` bits wide and wraps naturally. It must never exceed `LINE_WORDS`-1.
- `mem_req` is never asserted in IDLE.

## Timing

**Reset values**
- State IDLE, `line_valid`=0, `beat_cnt`=0, `mem_req`=0, `mem_addr`=0.
- With the aligned `fetch_addr`, `stall`=1 (miss), `fetch_err`=0, `inst`=word[...], which is don't-care while `stall`=1.

**Latencies**
- Hit: 0 cycles, combinational from `fetch_addr`.
- Miss with zero-wait memory (`mem_ack`=1 whenever `mem_req`=1):
  - Cycle 0: miss detected.
  - Cycles 1..`LINE_WORDS`: FILL beats.
  - Cycle `LINE_WORDS`+1: hit, `stall`=0. That is 5 stall cycles for `LINE_WORDS`=4.
- Each memory wait cycle adds one stall cycle.

**Reset mid-operation**
- Reset asserted mid-FILL forces IDLE and `mem_req`=0 immediately (asynchronous).
- The external memory must tolerate a dropped request.

**Registered vs combinational outputs**
- `mem_req` and `mem_addr` are registered outputs.
- `inst`, `stall` and `fetch_err` are combinational from `fetch_addr` and registered state.

## Test plan

1. **Cold fetch:** release reset, `fetch_addr`=0x0, zero-wait memory returning word = address.
   - Expect `mem_addr` 0x0, 0x4, 0x8, 0xC on consecutive cycles.
   - Expect `stall`=1 for 5 cycles, then `inst`=0x0.
2. **Sequential hits:** after test 1, step `fetch_addr` 0x4→0x8→0xC.
   - Expect `stall`=0 every cycle, `inst`=0x4, 0x8, 0xC, and `mem_req`=0.
3. **Line miss with wait states:** `fetch_addr`=0x10, memory acks every 3rd cycle.
   - Expect `mem_addr` to be held stable per beat and `stall` to stay 1 until the 4th ack.
   - Expect `inst`=0x10 on the cycle after the 4th ack.
4. **Kill mid-fill:** `fetch_addr`=0x20, kill during beat 1 with `mem_ack`=0, new `fetch_addr`=0x0.
   - Expect `mem_req` held for 0x24 until its ack, then DRAIN→IDLE.
   - Expect line 0x0 to be refetched, `line_valid` never set for tag 0x20, and final `inst`=0x0.
5. **Misaligned fetch:** `fetch_addr`=0x6.
   - Expect `fetch_err`=1, `inst`=0x00000013, `stall`=0, and no `mem_req`.
6. **Flush and reset:** on a valid line 0x0, pulse `flush`.
   - Next cycle `fetch_addr`=0x0 → `stall`=1 and a refill starts.
   - Assert `reset` low mid-refill → `mem_req`=0 immediately and state IDLE.
